// File: rtl/ctrl_pipe_seq.sv
// Control-side pipeline for ID->EX->MEM->WB: moves decoded control bundles,
// applies stall/flush/memory-freeze, sequences halt as a drain, counts retirements.
module ctrl_pipe_seq #(
    parameter int EX_W      = 6,
    parameter int MEM_W     = 2,
    parameter int WB_W      = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [EX_W-1:0]      id_ex,
    input  logic [MEM_W-1:0]     id_mem,
    input  logic [WB_W-1:0]      id_wb,
    input  logic                 id_wwd,
    input  logic                 id_halt,
    input  logic                 stall,
    input  logic                 flush_id,
    input  logic                 mem_ready,
    output logic                 ex_valid,
    output logic [EX_W-1:0]      ex_ctrl,
    output logic                 mem_valid,
    output logic [MEM_W-1:0]     mem_ctrl,
    output logic                 wb_valid,
    output logic [WB_W-1:0]      wb_ctrl,
    output logic                 wb_reg_write,
    output logic                 output_active,
    output logic                 freeze,
    output logic                 issue_block,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] num_inst
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    typedef struct packed {
        logic             valid;
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
        logic             wwd;
        logic             halt;
    } ex_stage_t;

    typedef struct packed {
        logic             valid;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
        logic             wwd;
        logic             halt;
    } mem_stage_t;

    typedef struct packed {
        logic            valid;
        logic [WB_W-1:0] wb;
        logic            wwd;
        logic            halt;
    } wb_stage_t;

    state_e               state_q, state_d;
    ex_stage_t            ex_q, ex_d;
    mem_stage_t           mem_q, mem_d;
    wb_stage_t            wb_q, wb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 load_id;

    always_comb begin
        freeze      = mem_q.valid & (mem_q.mem[1] | mem_q.mem[0]) & ~mem_ready;
        issue_block = (state_q != RUN);
        load_id     = id_valid & ~stall & ~flush_id & ~issue_block & (state_q == RUN);
    end

    // Invalid stages always carry all-zero fields, so plain copies keep bubbles clean.
    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
        if (load_id) begin
            ex_d.valid = 1'b1;
            ex_d.ex    = id_ex;
            ex_d.mem   = id_mem;
            ex_d.wb    = id_wb;
            ex_d.wwd   = id_wwd;
            ex_d.halt  = id_halt;
        end
        mem_d.valid = ex_q.valid;
        mem_d.mem   = ex_q.mem;
        mem_d.wb    = ex_q.wb;
        mem_d.wwd   = ex_q.wwd;
        mem_d.halt  = ex_q.halt;
        wb_d.valid  = mem_q.valid;
        wb_d.wb     = mem_q.wb;
        wb_d.wwd    = mem_q.wwd;
        wb_d.halt   = mem_q.halt;
        // Memory wait: hold EX/MEM, drop a bubble into WB so nothing retires twice.
        if (freeze) begin
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (load_id && id_halt && !freeze) state_d = DRAIN;
            DRAIN:   if (wb_q.valid && wb_q.halt)       state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wb_q.valid && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_ctrl       = ex_q.ex;
    assign mem_valid     = mem_q.valid;
    assign mem_ctrl      = mem_q.mem;
    assign wb_valid      = wb_q.valid;
    assign wb_ctrl       = wb_q.wb;
    assign wb_reg_write  = wb_q.valid & wb_q.wb[0];
    assign output_active = wb_q.valid & wb_q.wwd;
    assign is_halted     = (state_q == HALTED);
    assign num_inst      = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// Directed bench for ctrl_pipe_seq: stimulus pushes expected WB bundles into a
// queue, a negedge monitor pops and compares them as instructions retire.
module tb_ctrl_pipe_seq;

    localparam int EX_W = 6, MEM_W = 2, WB_W = 5, CNT_WIDTH = 4;

    localparam logic [5:0] ADD_EX = 6'h02, ORI_EX = 6'h25, LWD_EX = 6'h20, SWD_EX = 6'h21, SUB_EX = 6'h06;
    localparam logic [1:0] LWD_MEM = 2'b10, SWD_MEM = 2'b01;
    localparam logic [4:0] ADD_WB = 5'h03, ORI_WB = 5'h01, LWD_WB = 5'h05, SUB_WB = 5'h03;

    logic                 clk = 1'b0, reset = 1'b1;
    logic                 id_valid, id_wwd, id_halt, stall, flush_id, mem_ready;
    logic [EX_W-1:0]      id_ex;
    logic [MEM_W-1:0]     id_mem;
    logic [WB_W-1:0]      id_wb;
    logic                 ex_valid, mem_valid, wb_valid, wb_reg_write, output_active;
    logic                 freeze, issue_block, is_halted;
    logic [EX_W-1:0]      ex_ctrl;
    logic [MEM_W-1:0]     mem_ctrl;
    logic [WB_W-1:0]      wb_ctrl;
    logic [CNT_WIDTH-1:0] num_inst;

    typedef struct {
        logic [4:0] wb;
        logic       oa;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    ctrl_pipe_seq #(.EX_W(EX_W), .MEM_W(MEM_W), .WB_W(WB_W), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex(id_ex), .id_mem(id_mem),
        .id_wb(id_wb), .id_wwd(id_wwd), .id_halt(id_halt), .stall(stall), .flush_id(flush_id),
        .mem_ready(mem_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .mem_valid(mem_valid),
        .mem_ctrl(mem_ctrl), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_reg_write(wb_reg_write),
        .output_active(output_active), .freeze(freeze), .issue_block(issue_block),
        .is_halted(is_halted), .num_inst(num_inst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic put(input logic [5:0] ex, input logic [1:0] mem, input logic [4:0] wb,
                       input logic w, input logic h);
        id_valid = 1'b1; id_ex = ex; id_mem = mem; id_wb = wb; id_wwd = w; id_halt = h;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_ex = '0; id_mem = '0; id_wb = '0; id_wwd = 1'b0; id_halt = 1'b0;
        stall = 1'b0; flush_id = 1'b0;
    endtask

    task automatic expect_wb(input logic [4:0] wb, input logic oa, input int lat);
        sb.push_back('{wb, oa, cyc + lat});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", 32'(sb.size()), 0);
        idle();
        mem_ready = 1'b1;
        reset = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    // Monitor: every retirement must match the oldest expected bundle and its due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: wb_ctrl=%0h retired, none expected (cycle %0d)", wb_ctrl, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("wb_ctrl", 32'(wb_ctrl), 32'(e.wb));
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(e.wb[0]));
                    chk("output_active", 32'(output_active), 32'(e.oa));
                    chk("wb_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("wb_gating", 32'({wb_reg_write, output_active}), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        idle();
        mem_ready = 1'b1;
        reset = 1'b1;
        nxt(); nxt();
        chk("reset_valids", 32'({ex_valid, mem_valid, wb_valid}), 0);
        chk("reset_ctrl", 32'({ex_ctrl, mem_ctrl, wb_ctrl}), 0);
        chk("reset_status", 32'({freeze, issue_block, is_halted}), 0);
        chk("reset_count", 32'(num_inst), 0);
        reset = 1'b0;

        // Straight-line flow
        put(ADD_EX, 2'b00, ADD_WB, 0, 0); expect_wb(ADD_WB, 0, 3); nxt();
        put(ORI_EX, 2'b00, ORI_WB, 0, 0); expect_wb(ORI_WB, 0, 3); nxt();
        put(LWD_EX, LWD_MEM, LWD_WB, 0, 0); expect_wb(LWD_WB, 0, 3); nxt();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("s1_no_freeze", 32'(freeze), 0);
            nxt();
        end
        chk("s1_num_inst", 32'(num_inst), 3);

        // Stall then stall+flush
        do_reset();
        put(SWD_EX, SWD_MEM, 5'h00, 0, 0); stall = 1'b1; nxt();
        chk("s2_stall_bubble", 32'(ex_valid), 0);
        stall = 1'b0; expect_wb(5'h00, 0, 3); nxt();
        chk("s2_swd_in_ex", 32'({ex_valid, ex_ctrl}), 32'({1'b1, SWD_EX}));
        put(ORI_EX, 2'b00, ORI_WB, 0, 0); stall = 1'b1; flush_id = 1'b1; nxt();
        chk("s2_flush_bubble", 32'(ex_valid), 0);
        idle();
        repeat (4) nxt();
        chk("s2_num_inst", 32'(num_inst), 1);

        // Memory wait: LWD held in MEM for three freeze cycles
        do_reset();
        put(LWD_EX, LWD_MEM, LWD_WB, 0, 0); expect_wb(LWD_WB, 0, 5); nxt();
        put(ADD_EX, 2'b00, ADD_WB, 0, 0); expect_wb(ADD_WB, 0, 5); mem_ready = 1'b0; nxt();
        put(ORI_EX, 2'b00, ORI_WB, 0, 0); expect_wb(ORI_WB, 0, 5);
        chk("s3_freeze_1", 32'(freeze), 1);
        chk("s3_mem_held", 32'({mem_valid, mem_ctrl}), 32'({1'b1, LWD_MEM}));
        nxt();
        chk("s3_freeze_2", 32'(freeze), 1);
        chk("s3_ex_held", 32'(ex_ctrl), 32'(ADD_EX));
        chk("s3_wb_bubble", 32'(wb_valid), 0);
        flush_id = 1'b1; nxt();
        chk("s3_freeze_3", 32'(freeze), 1);
        chk("s3_ex_held_flush", 32'({ex_valid, ex_ctrl}), 32'({1'b1, ADD_EX}));
        chk("s3_wb_bubble_2", 32'(wb_valid), 0);
        flush_id = 1'b0; mem_ready = 1'b1; nxt();
        chk("s3_unfreeze", 32'(freeze), 0);
        chk("s3_ori_in_ex", 32'(ex_ctrl), 32'(ORI_EX));
        idle();
        repeat (4) nxt();
        chk("s3_num_inst", 32'(num_inst), 3);

        // Halt drain
        do_reset();
        put(ADD_EX, 2'b00, ADD_WB, 0, 0); expect_wb(ADD_WB, 0, 3); nxt();
        put(6'h00, 2'b00, 5'h00, 1, 0); expect_wb(5'h00, 1, 3); nxt();
        chk("s4_run_before_hlt", 32'(issue_block), 0);
        put(6'h00, 2'b00, 5'h00, 0, 1); expect_wb(5'h00, 0, 3); nxt();
        chk("s4_block_after_hlt", 32'({issue_block, ex_valid}), 32'(2'b11));
        put(SUB_EX, 2'b00, SUB_WB, 0, 0); nxt();
        chk("s4_sub_blocked", 32'(ex_valid), 0);
        nxt();
        chk("s4_not_yet_halted", 32'(is_halted), 0);
        nxt();
        chk("s4_halted", 32'({is_halted, issue_block}), 32'(2'b11));
        chk("s4_num_inst", 32'(num_inst), 3);
        repeat (3) nxt();
        chk("s4_halt_held", 32'(is_halted), 1);
        chk("s4_pipe_empty", 32'({ex_valid, mem_valid, wb_valid}), 0);
        idle();

        // Halt killed by flush, then a real halt
        do_reset();
        put(6'h00, 2'b00, 5'h00, 0, 1); flush_id = 1'b1; nxt();
        chk("s5_flushed_hlt", 32'({issue_block, ex_valid}), 0);
        idle();
        repeat (3) nxt();
        chk("s5_still_run", 32'({is_halted, issue_block}), 0);
        put(6'h00, 2'b00, 5'h00, 0, 1); expect_wb(5'h00, 0, 3); nxt();
        idle();
        chk("s5_drain", 32'(issue_block), 1);
        repeat (3) nxt();
        chk("s5_halted", 32'(is_halted), 1);
        chk("s5_num_inst", 32'(num_inst), 1);

        // Counter saturation
        do_reset();
        repeat (20) begin
            put(ADD_EX, 2'b00, ADD_WB, 0, 0); expect_wb(ADD_WB, 0, 3); nxt();
        end
        idle();
        repeat (4) nxt();
        chk("s6_saturate", 32'(num_inst), 15);

        // Reset during drain
        do_reset();
        put(ADD_EX, 2'b00, ADD_WB, 0, 0); nxt();
        put(6'h00, 2'b00, 5'h00, 0, 1); nxt();
        chk("s6_in_drain", 32'(issue_block), 1);
        idle(); reset = 1'b1; nxt();
        chk("s6_reset_valids", 32'({ex_valid, mem_valid, wb_valid}), 0);
        chk("s6_reset_status", 32'({freeze, issue_block, is_halted}), 0);
        chk("s6_reset_count", 32'(num_inst), 0);
        reset = 1'b0;
        put(ORI_EX, 2'b00, ORI_WB, 0, 0); expect_wb(ORI_WB, 0, 3); nxt();
        idle();
        repeat (4) nxt();
        chk("s6_post_reset_count", 32'(num_inst), 1);
        chk("s6_post_reset_run", 32'(issue_block), 0);

        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_seq.md
Name: ctrl_pipe_seq

Overview:
- Parametrised successor to the single-cycle decode stage.
- Carries the decoded control bundle from ID through EX, MEM and WB pipeline registers.
- Applies hazard stall, branch flush and data-memory wait freeze to those registers, sequences halt as an orderly drain, and counts retired instructions.
- Sits between the ID-stage decoder and the datapath's pipeline registers; it owns every valid bit in the pipeline.

Parameters:
- EX_W, 6, width of EX-stage control field (ALU op + ALUSrcB).
- MEM_W, 2, width of MEM-stage control field; bit1 = d_readM, bit0 = d_writeM; must be >= 2.
- WB_W, 5, width of WB-stage control field; bit0 = RegWrite; upper bits are RegDst/MemtoReg, opaque here.
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ex  in  EX_W  EX control from decoder
- id_mem  in  MEM_W  MEM control from decoder
- id_wb  in  WB_W  WB control from decoder
- id_wwd  in  1  instruction is WWD
- id_halt  in  1  instruction is HLT
- stall  in  1  load-use hazard: bubble into EX, upstream holds
- flush_id  in  1  branch mispredict: kill instruction in ID
- mem_ready  in  1  data memory completes access this cycle
- ex_valid, ex_ctrl  out  1, EX_W  EX register
- mem_valid, mem_ctrl  out  1, MEM_W  MEM register
- wb_valid, wb_ctrl  out  1, WB_W  WB register
- wb_reg_write  out  1  wb_valid & wb_ctrl[0]
- output_active  out  1  wb_valid & WWD flag in WB
- freeze  out  1  memory wait; upstream must hold PC and IF/ID
- issue_block  out  1  halt draining; upstream must stop fetching
- is_halted  out  1  halt retired
- num_inst  out  CNT_WIDTH  retired count

Behaviour:
- Reset: all valids 0, all ctrl registers 0, internal wwd/halt flags 0, num_inst 0. State RUN, so freeze, issue_block and is_halted are 0.
- Reset mid-drain or mid-freeze returns to RUN with an empty pipeline.
- freeze = mem_valid & (mem_ctrl[1] | mem_ctrl[0]) & !mem_ready. It is combinational.
- Advance, normal case: ID→EX, EX→MEM, MEM→WB, each 1 cycle. Latency ID→WB is 3 cycles.
- EX load value: load_id = id_valid & !stall & !flush_id & !issue_block & state==RUN.
  - If load_id, EX takes the id fields with ex_valid=1.
  - Otherwise EX gets a bubble: valid=0, ctrl zeroed.
  - Priority: flush_id over stall. Both asserted gives a bubble.
- Freeze overrides stall, flush and load:
  - EX and MEM registers hold.
  - WB loads a bubble.
  - The ID instruction is not consumed, and flush_id is ignored while freeze=1; the upstream logic keeps it asserted.
- Ctrl fields of invalid stages are zero. wb_reg_write and output_active never assert without wb_valid.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN→DRAIN when load_id & id_halt & !freeze. The halt enters EX that cycle.
  - A halt that is flushed or stalled causes no transition.
  - DRAIN: issue_block=1, so only bubbles enter EX. Older instructions complete normally, including freezes.
  - DRAIN→HALTED on the cycle the halt is in WB with wb_valid=1. That is 3 cycles after entry when there are no freezes.
  - HALTED: is_halted=1, issue_block=1. All valids clear once the pipe empties. The state is held until reset.
- num_inst increments by 1 each cycle wb_valid=1, including for HLT. It saturates at 2^CNT_WIDTH-1 and does not wrap.
- Because freeze feeds a bubble into WB, no instruction is ever counted twice.

Test Plan:
- Straight-line flow: ADD, ORI, LWD issued on consecutive cycles with mem_ready=1.
  - Expect each at WB 3 cycles after ID with matching ctrl.
  - Expect num_inst = 3, freeze never asserted.
- Stall and flush:
  - stall=1 for 1 cycle on a SWD gives one ex_valid=0 bubble; SWD enters EX the next cycle.
  - stall=1 together with flush_id=1 gives a bubble, and that instruction never reaches WB.
  - num_inst excludes the flushed instruction.
- Memory wait: LWD in MEM with mem_ready=0 for 3 cycles.
  - Expect freeze=1 for 3 cycles, EX/MEM held, wb_valid=0 for 3 cycles.
  - LWD retires once; num_inst +1.
- Halt drain: ADD, WWD, HLT, SUB issued back to back.
  - SUB never enters EX; issue_block=1 from the cycle after HLT enters EX.
  - output_active pulses for WWD; is_halted=1 when HLT reaches WB; num_inst = 3.
- Halt killed:
  - HLT in ID with flush_id=1: state stays RUN, is_halted stays 0.
  - Later HLT without flush halts normally.
- Reset and saturation:
  - With CNT_WIDTH=4, retire 20 instructions: num_inst = 15.
  - reset asserted during DRAIN: all outputs 0 the next cycle, and a new instruction flows normally.
